// File: rtl/riscv_cpu_pkg.sv
// rtl/riscv_cpu_pkg.sv - shared core types used by the data-memory responder
package riscv_cpu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
  } dmem_rsp_t;

  // Merge the enabled byte lanes of new_word into old_word.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BE_WIDTH-1:0]   be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/lfsr_stall_gen.sv
// rtl/lfsr_stall_gen.sv - 16-bit Fibonacci LFSR (taps 16,14,13,11) stall generator
module lfsr_stall_gen #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic stall_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign stall_o = en_i & (lfsr_q[1:0] == 2'b00);

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data SRAM responder with fixed latency
module data_mem_responder
  import riscv_cpu_pkg::*;
#(
  parameter int          DEPTH        = 1024,
  parameter int          READ_LATENCY = 1,
  parameter bit          STALL_EN     = 1'b0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [DATA_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic                  stall;
  logic                  accept;
  logic                  in_range;
  logic [IDX_W-1:0]      widx;
  logic                  unused_addr_lsb;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  dmem_rsp_t             rsp_new;
  dmem_rsp_t             pipe_q [READ_LATENCY];
  dmem_rsp_t             pipe_d [READ_LATENCY];

  lfsr_stall_gen #(
    .SEED (LFSR_SEED)
  ) u_stall (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (STALL_EN),
    .stall_o (stall)
  );

  assign data_gnt_o      = data_req_i & ~stall & ~rst_i;
  assign accept          = data_gnt_o;
  assign widx            = data_addr_i[IDX_W+1:2];
  assign in_range        = (data_addr_i[DATA_WIDTH-1:IDX_W+2] == '0);
  assign unused_addr_lsb = ^data_addr_i[1:0];

  // Storage has no reset so contents survive a mid-run reset.
  always_ff @(posedge clk_i) begin
    if (accept && data_we_i && in_range) begin
      mem[widx] <= merge_bytes(mem[widx], data_wdata_i, data_be_i);
    end
  end

  always_comb begin
    rsp_new       = '0;
    rsp_new.valid = accept;
    rsp_new.err   = accept & ~in_range;
    if (accept && in_range && !data_we_i) rsp_new.rdata = mem[widx];
    pipe_d[0] = rsp_new;
    for (int i = 1; i < READ_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign data_rvalid_o = pipe_q[READ_LATENCY-1].valid;
  assign data_err_o    = pipe_q[READ_LATENCY-1].err;
  assign data_rdata_o  = pipe_q[READ_LATENCY-1].rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - bench for data_mem_responder (three configurations)
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req    [3];
  logic        gnt    [3];
  logic        we     [3];
  logic        rvalid [3];
  logic        err    [3];
  logic [3:0]  be     [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic [31:0] rdata  [3];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endfunction

  // k0: latency 1, no stall; k1: latency 3, no stall; k2: latency 2, stalls, 16 words
  data_mem_responder #(.DEPTH(1024), .READ_LATENCY(1), .STALL_EN(1'b0)) u_k0 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req[0]), .data_gnt_o(gnt[0]),
    .data_addr_i(addr[0]), .data_we_i(we[0]), .data_be_i(be[0]), .data_wdata_i(wdata[0]),
    .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0]));

  data_mem_responder #(.DEPTH(1024), .READ_LATENCY(3), .STALL_EN(1'b0)) u_k1 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
    .data_addr_i(addr[1]), .data_we_i(we[1]), .data_be_i(be[1]), .data_wdata_i(wdata[1]),
    .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1]));

  data_mem_responder #(.DEPTH(16), .READ_LATENCY(2), .STALL_EN(1'b1), .LFSR_SEED(16'hACE1)) u_k2 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req[2]), .data_gnt_o(gnt[2]),
    .data_addr_i(addr[2]), .data_we_i(we[2]), .data_be_i(be[2]), .data_wdata_i(wdata[2]),
    .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]), .data_err_o(err[2]));

  typedef struct {
    int          due;
    bit          err;
    bit          known;
    logic [31:0] data;
  } exp_t;

  // Model: byte-addressed memory plus a queue of timestamped expected responses.
  for (genvar k = 0; k < 3; k++) begin : g_model
    localparam int RL  = (k == 0) ? 1 : (k == 1) ? 3 : 2;
    localparam bit ST  = (k == 2);
    localparam int DEP = (k == 2) ? 16 : 1024;

    logic [7:0]  mem_m [int];
    exp_t        q [$];
    logic [15:0] lfsr_m = 16'hACE1;

    always @(negedge clk) begin
      bit          g_exp;
      exp_t        e;
      int unsigned idx;
      if (rst) begin
        q.delete();
        lfsr_m = 16'hACE1;
        chk($sformatf("k%0d_rst_gnt", k), 32'(gnt[k]), 32'd0);
        chk($sformatf("k%0d_rst_rvalid", k), 32'(rvalid[k]), 32'd0);
        chk($sformatf("k%0d_rst_err", k), 32'(err[k]), 32'd0);
        chk($sformatf("k%0d_rst_rdata", k), rdata[k], 32'd0);
      end else begin
        g_exp = req[k] && !(ST && lfsr_m[1:0] == 2'b00);
        chk($sformatf("k%0d_gnt", k), 32'(gnt[k]), 32'(g_exp));
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          chk($sformatf("k%0d_rvalid", k), 32'(rvalid[k]), 32'd1);
          chk($sformatf("k%0d_err", k), 32'(err[k]), 32'(e.err));
          if (e.known) chk($sformatf("k%0d_rdata", k), rdata[k], e.data);
        end else begin
          chk($sformatf("k%0d_idle_rvalid", k), 32'(rvalid[k]), 32'd0);
          chk($sformatf("k%0d_idle_rdata", k), rdata[k], 32'd0);
          chk($sformatf("k%0d_idle_err", k), 32'(err[k]), 32'd0);
        end
        if (g_exp) begin
          idx     = addr[k][31:2];
          e.due   = cyc + RL;
          e.err   = (idx >= DEP);
          e.known = 1'b1;
          e.data  = 32'd0;
          if (!e.err && we[k]) begin
            for (int b = 0; b < 4; b++)
              if (be[k][b]) mem_m[int'(idx * 4 + b)] = wdata[k][8*b +: 8];
          end else if (!e.err) begin
            for (int b = 0; b < 4; b++) begin
              if (mem_m.exists(int'(idx * 4 + b))) e.data[8*b +: 8] = mem_m[int'(idx * 4 + b)];
              else e.known = 1'b0;
            end
          end
          q.push_back(e);
        end
        lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
      end
    end
  end

  int          g1_cyc [$];
  int          r1_cyc [$];
  logic [31:0] r1_dat [$];
  int          gcnt2 = 0;
  int          rcnt2 = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (req[1] && gnt[1]) g1_cyc.push_back(cyc);
      if (rvalid[1]) begin
        r1_cyc.push_back(cyc);
        r1_dat.push_back(rdata[1]);
      end
      if (req[2] && gnt[2]) gcnt2++;
      if (rvalid[2]) rcnt2++;
    end
  end

  task automatic xact(input int k, input bit w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d);
    bit g;
    int n;
    n = 0;
    req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
    do begin
      @(negedge clk);
      g = gnt[k];
      @(posedge clk);
      #1;
      n++;
    end while (!g && n < 64);
    chk("xact_granted", 32'(g), 32'd1);
    req[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] wv [4];
  logic [4:0]  pat;
  int          t0;

  initial begin
    wv = '{32'h0A0A0000, 32'h1B1B1111, 32'h2C2C2222, 32'h3D3D3333};
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; be[k] = 4'h0; addr[k] = '0; wdata[k] = '0;
    end
    idle(2);
    req[0] = 1'b1;
    #1;
    chk("rst_gnt_masked", 32'(gnt[0]), 32'd0);
    chk("rst_rvalid1", 32'(rvalid[1]), 32'd0);
    req[0] = 1'b0;
    idle(1);
    rst = 1'b0;

    // LFSR pin: seed ACE1 -> 5670, AB38, 559C, 2ACE gives grants 1,0,0,0,1
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h0; be[2] = 4'hF; wdata[2] = 32'hA5A5A5A5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pat = {pat[3:0], gnt[2]};
      @(posedge clk);
      #1;
    end
    req[2] = 1'b0;
    chk("lfsr_gnt_pattern", 32'(pat), 32'b10001);

    xact(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    xact(0, 1'b0, 32'h10, 4'hF, 32'h0);
    chk("t1_rvalid", 32'(rvalid[0]), 32'd1);
    chk("t1_rdata", rdata[0], 32'hDEADBEEF);
    chk("t1_err", 32'(err[0]), 32'd0);

    xact(0, 1'b1, 32'h10, 4'b0010, 32'h0000AB00);
    xact(0, 1'b0, 32'h13, 4'hF, 32'h0);
    chk("t2_be_merge", rdata[0], 32'hDEADABEF);
    xact(0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF);
    xact(0, 1'b0, 32'h10, 4'hF, 32'h0);
    chk("t2_be_zero", rdata[0], 32'hDEADABEF);
    chk("t2_be_zero_rvalid", 32'(rvalid[0]), 32'd1);

    xact(0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D);
    xact(0, 1'b1, 32'h1000, 4'hF, 32'h12345678);
    chk("t5_wr_err", 32'(err[0]), 32'd1);
    xact(0, 1'b0, 32'h1000, 4'hF, 32'h0);
    chk("t5_rd_rvalid", 32'(rvalid[0]), 32'd1);
    chk("t5_rd_err", 32'(err[0]), 32'd1);
    chk("t5_rd_rdata", rdata[0], 32'd0);
    xact(0, 1'b0, 32'h0, 4'hF, 32'h0);
    chk("t5_word0", rdata[0], 32'hCAFEF00D);

    for (int i = 0; i < 4; i++) xact(1, 1'b1, 32'(4 * i), 4'hF, wv[i]);
    idle(4);
    g1_cyc.delete(); r1_cyc.delete(); r1_dat.delete();
    for (int i = 0; i < 4; i++) xact(1, 1'b0, 32'(4 * i), 4'hF, 32'h0);
    idle(5);
    chk("t3_grants", 32'(g1_cyc.size()), 32'd4);
    chk("t3_rsps", 32'(r1_cyc.size()), 32'd4);
    if (r1_cyc.size() == 4 && g1_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t3_data%0d", i), r1_dat[i], wv[i]);
        chk($sformatf("t3_lat%0d", i), 32'(r1_cyc[i] - g1_cyc[i]), 32'd3);
        chk($sformatf("t3_b2b%0d", i), 32'(r1_cyc[i] - r1_cyc[0]), 32'(i));
      end
    end

    r1_cyc.delete(); r1_dat.delete();
    xact(1, 1'b0, 32'h0, 4'hF, 32'h0);
    xact(1, 1'b0, 32'h4, 4'hF, 32'h0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(6);
    chk("t6_no_rsp_after_rst", 32'(r1_cyc.size()), 32'd0);
    xact(1, 1'b0, 32'h8, 4'hF, 32'h0);
    idle(2);
    chk("t6_rvalid", 32'(rvalid[1]), 32'd1);
    chk("t6_retained", rdata[1], wv[2]);

    for (int i = 0; i < 16; i++) xact(2, 1'b1, 32'(4 * i), 4'hF, 32'($urandom));
    idle(3);
    gcnt2 = 0;
    rcnt2 = 0;
    t0 = cyc;
    while (cyc - t0 < 200) begin
      xact(2, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 127)),
           4'($urandom_range(0, 15)), 32'($urandom));
    end
    idle(4);
    chk("t4_rsp_eq_gnt", 32'(rcnt2), 32'(gcnt2));
    chk("t4_some_grants", 32'(gcnt2 > 40), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
